div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU, instantiated beside the EX stage.
- EX drives operands/start and holds its stall request until ready_o.
- The {remainder, quotient} result becomes ex_hi/ex_lo with ex_whilo asserted into the EX/MEM pipeline register.
- Produces one quotient bit per cycle, MSB first.

Parameters:
WIDTH, 32, operand width; result_o is 2*WIDTH.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (rst==0 resets)
signed_div_i  input  1  1=DIV (two's complement), 0=DIVU
opdata1_i  input  WIDTH  dividend
opdata2_i  input  WIDTH  divisor
start_i  input  1  request; held high by EX until ready_o seen
annul_i  input  1  abort (pipeline flush); overrides start_i
result_o  output  2*WIDTH  {remainder, quotient}; hi=remainder, lo=quotient
ready_o  output  1  result_o valid

Behaviour:
- Reset (rst low, async): state=FREE, cnt=0, result_o=0, ready_o=0, internal regs=0.
- All outputs registered; result_o=0 and ready_o=0 in every state except END.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1 & annul_i=0 & opdata2_i==0 -> BYZERO.
  - start_i=1 & annul_i=0 & opdata2_i!=0 -> ON.
    - Latch |opdata1_i| and |opdata2_i| when signed_div_i=1 (two's-complement negate if MSB set); otherwise latch raw.
    - Also latch the sign flags and signed_div_i. cnt=0.
  - Otherwise stay in FREE.
- BYZERO: next edge -> END with remainder=0, quotient=0.
- ON (annul_i=0):
  - Each edge: partial remainder shifted left, next dividend bit shifted in, then trial subtract of the divisor.
  - If no borrow, keep the difference and quotient bit=1; else restore and quotient bit=0. cnt++.
  - Trial subtraction is WIDTH+1 bits wide; the borrow is bit WIDTH.
- ON, cnt==WIDTH: next edge -> END.
  - Quotient sign fix: negate if signed and dividend sign != divisor sign.
  - Remainder sign fix: negate if signed and dividend negative.
  - Latch into result_o; ready_o=1.
- ON, annul_i=1: next edge -> FREE, cnt=0, outputs 0; partial result discarded.
- END:
  - While start_i=1, hold result_o/ready_o stable; operand changes are ignored.
  - start_i=0 -> next edge FREE, ready_o=0, result_o=0.
  - annul_i=1 also -> FREE.
- Latency, edge E0 samples start:
  - nonzero divisor: ready_o=1 after edge E(WIDTH+1), i.e. 34 edges for WIDTH=32.
  - zero divisor: ready_o=1 after E1.
- Operand changes after E0 have no effect until the next FREE->ON.
- Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. No exception; wraps naturally.
- Division by zero does not trap; the result is defined as 0/0.
- Async reset mid-ON or mid-END aborts immediately to the reset values; the first start after reset behaves normally.
- No back-to-back start from END: start_i must drop for at least one cycle so the FSM passes through FREE.

Test Plan:
- Unsigned: opdata1=100, opdata2=7, signed=0, start held -> ready_o rises after edge 33 past E0 (34th edge); result_o=0x00000002_0000000E; drop start -> ready_o=0, result_o=0 next edge.
- Signed sign rules:
  - -7/2 (0xFFFFFFF9/0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD.
  - 7/-2 -> 0x00000001_FFFFFFFD.
  - -7/-2 -> 0xFFFFFFFF_00000003.
- Boundaries:
  - unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
  - signed 0x80000000/0xFFFFFFFF -> 0x00000000_80000000.
  - 5/9 unsigned -> 0x00000005_00000000.
- Divide by zero: 1234/0 -> ready_o=1 after E1, result_o=0; held while start high.
- Annul: start 100/7, assert annul_i at iteration 10 -> FREE next edge, ready_o stays 0. Then restart 50/5 -> 0x00000000_0000000A after 34 edges.
- Reset: drive rst low asynchronously mid-ON (between edges) -> ready_o/result_o 0 immediately. Release, start 9/3 -> 0x00000000_00000003 with normal latency.

Source files
------------

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle radix-2 restoring divider for DIV/DIVU, sitting beside the EX
// stage. EX holds start_i (and its stall) until ready_o is seen. The divider
// produces one quotient bit per cycle, MSB first, on operand magnitudes. It
// applies the two's-complement sign fix-up when it finishes.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   signed_div_i 1 = DIV (two's complement), 0 = DIVU
//   opdata1_i    dividend
//   opdata2_i    divisor
//   start_i      request, held high by EX until ready_o is observed
//   annul_i      abort (pipeline flush), overrides start_i
//   result_o     {remainder, quotient}; feeds ex_hi / ex_lo
//   ready_o      result_o valid
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_BYZERO = 2'd1;
    localparam logic [1:0] ST_ON     = 2'd2;
    localparam logic [1:0] ST_END    = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    // The dividend register doubles as the quotient register. Each cycle one
    // dividend bit leaves at the top and one quotient bit enters at the bottom.
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic             neg1;
    logic             neg2;
    logic             sdiv;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;

    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v,
                                                   input logic             n);
        return n ? ((~v) + WIDTH'(1)) : v;
    endfunction

    // The most negative value maps onto itself. As an unsigned magnitude it is
    // still correct, so 0x80000000 / -1 wraps naturally.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic                    is_signed);
        return negate_if(v, is_signed && (v < 0));
    endfunction

    // Trial subtraction is one bit wider than the operands. Bit WIDTH is the
    // borrow, which is set when the shifted remainder is below the divisor.
    assign shifted = {rem, dividend[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};
    assign borrow  = diff[WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_FREE;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            neg1     <= 1'b0;
            neg2     <= 1'b0;
            sdiv     <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                ST_FREE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= ST_BYZERO;
                        end else begin
                            state    <= ST_ON;
                            dividend <= magnitude(opdata1_i, signed_div_i);
                            divisor  <= magnitude(opdata2_i, signed_div_i);
                            rem      <= '0;
                            neg1     <= opdata1_i[WIDTH-1];
                            neg2     <= opdata2_i[WIDTH-1];
                            sdiv     <= signed_div_i;
                            cnt      <= '0;
                        end
                    end
                end

                ST_BYZERO: begin
                    if (annul_i) begin
                        state <= ST_FREE;
                    end else begin
                        state    <= ST_END;
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                end

                ST_ON: begin
                    if (annul_i) begin
                        state <= ST_FREE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state    <= ST_END;
                        result_o <= {negate_if(rem, sdiv && neg1),
                                     negate_if(dividend, sdiv && (neg1 != neg2))};
                        ready_o  <= 1'b1;
                    end else begin
                        rem      <= borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                        dividend <= {dividend[WIDTH-2:0], ~borrow};
                        cnt      <= cnt + CNT_W'(1);
                    end
                end

                ST_END: begin
                    // Result stays put while EX keeps start_i high. The FSM
                    // must pass through FREE before it accepts a new request.
                    if (annul_i || !start_i) begin
                        state    <= ST_FREE;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_FREE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Scoreboard bench for div_unit. Each request pushes its expected result and
// the cycle at which ready_o must rise. A monitor pops and compares on every
// rising ready_o.
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    typedef struct {
        logic [63:0] res;
        int          due;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_checks;
    int   n_fail;
    logic prev_ready;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising edge of ready_o must match the oldest expectation.
    initial prev_ready = 1'b0;
    always @(negedge clk) begin
        if (ready && !prev_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_ready", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_result"}, result, e.res);
                chk({e.name, "_latency"}, 64'(cyc), 64'(e.due));
            end
        end
        prev_ready <= ready;
    end

    // Issue one division and wait for completion. Hold start for two extra
    // cycles with scrambled operands, which must not matter. Then either drop
    // start or hit the asynchronous reset while the FSM sits in END.
    task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] exp, input int lat,
                       input bit rst_in_end);
        int k;
        @(negedge clk);
        opdata1    = a;
        opdata2    = b;
        signed_div = s;
        start      = 1'b1;
        q.push_back('{exp, cyc + lat, name});
        k = 0;
        while (!ready && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (!ready) chk({name, "_timeout"}, 64'd0, 64'd1);
        opdata1 = ~a;
        opdata2 = 32'h0;
        signed_div = ~s;
        repeat (2) begin
            @(negedge clk);
            chk({name, "_hold_ready"}, 64'(ready), 64'd1);
            chk({name, "_hold_result"}, result, exp);
        end
        if (rst_in_end) begin
            #2 rst = 1'b0;
            #1;
            chk({name, "_rst_ready"}, 64'(ready), 64'd0);
            chk({name, "_rst_result"}, result, 64'd0);
            start = 1'b0;
            @(negedge clk);
            rst = 1'b1;
        end else begin
            start = 1'b0;
            @(negedge clk);
            chk({name, "_drop_ready"}, 64'(ready), 64'd0);
            chk({name, "_drop_result"}, result, 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        opdata1    = 32'd0;
        opdata2    = 32'd0;

        repeat (2) @(negedge clk);
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_result", result, 64'd0);
        rst = 1'b1;

        run("u100_7",    32'd100,       32'd7,         1'b0, 64'h00000002_0000000E, 34, 1'b0);
        run("s_m7_2",    32'hFFFFFFF9,  32'h00000002,  1'b1, 64'hFFFFFFFF_FFFFFFFD, 34, 1'b0);
        run("s_7_m2",    32'h00000007,  32'hFFFFFFFE,  1'b1, 64'h00000001_FFFFFFFD, 34, 1'b0);
        run("s_m7_m2",   32'hFFFFFFF9,  32'hFFFFFFFE,  1'b1, 64'hFFFFFFFF_00000003, 34, 1'b0);
        run("u_max_1",   32'hFFFFFFFF,  32'h00000001,  1'b0, 64'h00000000_FFFFFFFF, 34, 1'b0);
        run("s_ovf",     32'h80000000,  32'hFFFFFFFF,  1'b1, 64'h00000000_80000000, 34, 1'b0);
        run("u5_9",      32'd5,         32'd9,         1'b0, 64'h00000005_00000000, 34, 1'b0);
        run("byzero",    32'd1234,      32'd0,         1'b0, 64'h00000000_00000000, 2,  1'b0);

        // Annul at iteration 10: the result is discarded and ready_o never rises.
        @(negedge clk);
        opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        repeat (10) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready) break;
        end
        chk("annul_ready", 64'(ready), 64'd0);
        chk("annul_result", result, 64'd0);
        run("u50_5",     32'd50,        32'd5,         1'b0, 64'h00000000_0000000A, 34, 1'b0);

        // Asynchronous reset mid-ON, between clock edges.
        @(negedge clk);
        opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_on_ready", 64'(ready), 64'd0);
        chk("rst_on_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (ready) break;
        end
        chk("rst_on_after_ready", 64'(ready), 64'd0);
        run("u9_3",      32'd9,         32'd3,         1'b0, 64'h00000000_00000003, 34, 1'b0);

        // Asynchronous reset while in END, then a normal division.
        run("s_m100_7",  32'hFFFFFF9C,  32'd7,         1'b1, 64'hFFFFFFFE_FFFFFFF2, 34, 1'b1);
        run("u_post",    32'd1000,      32'd10,        1'b0, 64'h00000000_00000064, 34, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
